// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: operands latched on start, summed CHUNK bits per
// clock LSB slice first through a registered carry; start/busy/done handshake.
module seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zr
);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "seq_adder: CHUNK must be >=1 and divide WIDTH (>=2)");
    end
  endgenerate

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zr_q, zr_d;

  int unsigned        base;
  logic [CHUNK:0]     slice_sum;
  logic               msb_cin;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zr_d    = zr_q;

    base      = CHUNK * 32'(idx_q);
    slice_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of a slice recovered from its sum bit and operands.
    msb_cin   = slice_sum[CHUNK-1] ^ a_q[base + CHUNK - 1] ^ b_q[base + CHUNK - 1];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d              = slice_sum[CHUNK];
        idx_d                = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = S_DONE;
          out_d   = res_d;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = msb_cin ^ slice_sum[CHUNK];
          zr_d    = (res_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zr_q    <= zr_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zr   = zr_q;

endmodule
